// File: rtl/sdram_init_sequencer.sv
// SDRAM initialisation sequencer: power-up wait, PRECHARGE ALL,
// N x AUTO REFRESH, LOAD MODE, plus run-time re-init via bus req/gnt.
module sdram_init_sequencer #(
    parameter int unsigned POWER_UP_CYCLES = 20000,
    parameter int unsigned TRP_CYCLES      = 2,
    parameter int unsigned TRFC_CYCLES     = 7,
    parameter int unsigned TMRD_CYCLES     = 2,
    parameter int unsigned NUM_REFRESH     = 8,
    parameter int unsigned ADDR_W          = 13,
    parameter logic [ADDR_W-1:0] MODE_REG  = 13'h033,
    parameter int unsigned BA_W            = 2,
    parameter int unsigned NUM_CS          = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              reinit_i,
    input  logic [ADDR_W-1:0] mode_reg_i,
    input  logic              bus_gnt_i,
    output logic              bus_req_o,
    output logic              cke_o,
    output logic [NUM_CS-1:0] cs_n_o,
    output logic              ras_n_o,
    output logic              cas_n_o,
    output logic              we_n_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BA_W-1:0]   ba_o,
    output logic              init_busy_o,
    output logic              init_done_o
);

    localparam int unsigned RC_W = $clog2(NUM_REFRESH + 1);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    localparam logic [31:0] T_PWR = 32'(POWER_UP_CYCLES - 1);
    localparam logic [31:0] T_RP  = 32'(TRP_CYCLES - 1);
    localparam logic [31:0] T_RFC = 32'(TRFC_CYCLES - 1);
    localparam logic [31:0] T_MRD = 32'(TMRD_CYCLES - 1);

    localparam logic [RC_W-1:0]   RC_INIT = RC_W'(NUM_REFRESH);
    localparam logic [RC_W-1:0]   RC_LAST = RC_W'(1);
    localparam logic [ADDR_W-1:0] A10     = ADDR_W'(1024);

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_PRE,
        S_REF,
        S_MRS,
        S_MRD,
        S_DONE,
        S_REQ
    } state_t;

    state_t            state_q;
    logic [31:0]       timer_q;
    logic [RC_W-1:0]   ref_cnt_q;
    logic [ADDR_W-1:0] mode_q;

    logic              cke_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic [2:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BA_W-1:0]   ba_q;
    logic              req_q;
    logic              busy_q;
    logic              done_q;

    // Sequencer FSM; each state times its gap then issues one command.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_PWR_WAIT;
            timer_q   <= T_PWR;
            ref_cnt_q <= '0;
            mode_q    <= MODE_REG;
            cke_q     <= 1'b0;
            cs_n_q    <= '1;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            ba_q      <= '0;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            cke_q  <= 1'b1;
            cs_n_q <= '0;
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            ba_q   <= '0;
            unique case (state_q)
                S_PWR_WAIT: begin
                    if (timer_q == 32'd0) begin
                        state_q <= S_PRE;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                S_PRE: begin
                    cmd_q     <= CMD_PRE;
                    addr_q    <= A10;
                    timer_q   <= T_RP;
                    ref_cnt_q <= RC_INIT;
                    state_q   <= S_REF;
                end
                S_REF: begin
                    if (timer_q == 32'd0) begin
                        cmd_q     <= CMD_REF;
                        timer_q   <= T_RFC;
                        ref_cnt_q <= ref_cnt_q - RC_LAST;
                        if (ref_cnt_q == RC_LAST) begin
                            state_q <= S_MRS;
                        end
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                S_MRS: begin
                    if (timer_q == 32'd0) begin
                        cmd_q   <= CMD_MRS;
                        addr_q  <= mode_q;
                        timer_q <= T_MRD;
                        state_q <= S_MRD;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                S_MRD: begin
                    if (timer_q == 32'd0) begin
                        state_q <= S_DONE;
                        cs_n_q  <= '1;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                S_DONE: begin
                    cs_n_q <= '1;
                    if (reinit_i) begin
                        mode_q  <= mode_reg_i;
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_REQ: begin
                    cs_n_q <= '1;
                    if (bus_gnt_i) begin
                        state_q <= S_PRE;
                    end
                end
                default: begin
                    state_q <= S_PWR_WAIT;
                end
            endcase
        end
    end

    assign bus_req_o   = req_q;
    assign cke_o       = cke_q;
    assign cs_n_o      = cs_n_q;
    assign ras_n_o     = cmd_q[2];
    assign cas_n_o     = cmd_q[1];
    assign we_n_o      = cmd_q[0];
    assign addr_o      = addr_q;
    assign ba_o        = ba_q;
    assign init_busy_o = busy_q;
    assign init_done_o = done_q;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Bench for sdram_init_sequencer: randomized re-init traffic checked
// against a cycle-schedule model derived from the command timing rules.
module tb_sdram_init_sequencer;

    localparam int P    = 10;
    localparam int TRP  = 2;
    localparam int TRFC = 7;
    localparam int N    = 8;
    localparam int TMRD = 2;

    // Vector layout: cke, cs_n, ras/cas/we, addr[12:0], ba[1:0], req, busy, done
    localparam logic [22:0] RST_V = {1'b0, 1'b1, 3'b111, 13'h0, 2'b0, 3'b110};
    localparam logic [22:0] REQ_V = {1'b1, 1'b1, 3'b111, 13'h0, 2'b0, 3'b110};

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        reinit = 1'b0;
    logic [12:0] mode_in = 13'h0;
    logic        gnt = 1'b0;
    logic        req, cke, cs_n, ras, cas, we, busy, done;
    logic [12:0] addr;
    logic [1:0]  ba;

    logic        reinit_e = 1'b0;
    logic [12:0] mode_e = 13'h0;
    logic        gnt_e = 1'b0;
    logic        req_e, cke_e, ras_e, cas_e, we_e, busy_e, done_e;
    logic [1:0]  cs_e;
    logic [12:0] addr_e;
    logic [1:0]  ba_e;

    logic [22:0] obs, obs_e;
    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    sdram_init_sequencer #(
        .POWER_UP_CYCLES(P), .TRP_CYCLES(TRP), .TRFC_CYCLES(TRFC),
        .TMRD_CYCLES(TMRD), .NUM_REFRESH(N)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .reinit_i(reinit),
        .mode_reg_i(mode_in), .bus_gnt_i(gnt), .bus_req_o(req),
        .cke_o(cke), .cs_n_o(cs_n), .ras_n_o(ras), .cas_n_o(cas),
        .we_n_o(we), .addr_o(addr), .ba_o(ba),
        .init_busy_o(busy), .init_done_o(done)
    );

    sdram_init_sequencer #(
        .POWER_UP_CYCLES(1), .TRP_CYCLES(1), .TRFC_CYCLES(1),
        .TMRD_CYCLES(1), .NUM_REFRESH(1), .NUM_CS(2)
    ) dut_e (
        .HCLK(HCLK), .HRESETn(HRESETn), .reinit_i(reinit_e),
        .mode_reg_i(mode_e), .bus_gnt_i(gnt_e), .bus_req_o(req_e),
        .cke_o(cke_e), .cs_n_o(cs_e), .ras_n_o(ras_e), .cas_n_o(cas_e),
        .we_n_o(we_e), .addr_o(addr_e), .ba_o(ba_e),
        .init_busy_o(busy_e), .init_done_o(done_e)
    );

    assign obs = {cke, cs_n, ras, cas, we, addr, ba, req, busy, done};
    assign obs_e = {cke_e, cs_e[0], ras_e, cas_e, we_e, addr_e, ba_e,
                    req_e, busy_e, done_e};

    // Expected outputs c cycles into a sequence whose PRE lands at cycle p.
    function automatic logic [22:0] model(input int c, input int p,
                                          input int trp, input int trfc,
                                          input int n, input int tmrd,
                                          input logic [12:0] mode);
        logic [22:0] v;
        int r;
        int m;
        r = c - p - trp;
        m = p + trp + n * trfc;
        v = {1'b1, 1'b0, 3'b111, 13'h0, 2'b0, 3'b110};
        if (c == p) begin
            v[20:5] = {3'b010, 13'h400};
        end else if (r >= 0 && (r % trfc) == 0 && (r / trfc) < n) begin
            v[20:18] = 3'b001;
        end else if (c == m) begin
            v[20:5] = {3'b000, mode};
        end else if (c >= m + tmrd) begin
            v[21] = 1'b1;
            v[2:0] = 3'b001;
        end
        return v;
    endfunction

    task automatic assert_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        reinit = 1'b0;
        gnt = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic run_powerup(input bit noisy);
        int dc;
        logic [22:0] e;
        dc = P + TRP + N * TRFC + TMRD;
        for (int c = 0; c <= dc + 3; c++) begin
            reinit = noisy && c <= dc &&
                     ($urandom_range(0, 3) == 0 || c == dc);
            mode_in = 13'($urandom);
            gnt = noisy ? 1'($urandom) : 1'b0;
            @(posedge HCLK);
            #1;
            e = model(c, P, TRP, TRFC, N, TMRD, 13'h033);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL powerup c=%0d got %h exp %h", c, obs, e);
            end
        end
        reinit = 1'b0;
        gnt = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (obs !== RST_V) begin
            errors++;
            $display("FAIL reset_main got %h exp %h", obs, RST_V);
        end
        checks++;
        if ({obs_e, cs_e} !== {RST_V, 2'b11}) begin
            errors++;
            $display("FAIL reset_edge got %h/%b exp %h/11", obs_e, cs_e, RST_V);
        end
        release_reset();
    endtask

    task automatic test_power_up();
        run_powerup(1'b0);
    endtask

    task automatic test_reinit(input int k, input logic [12:0] m);
        int drop;
        logic [22:0] e;
        reinit = 1'b1;
        mode_in = m;
        @(posedge HCLK);
        #1;
        reinit = 1'b0;
        checks++;
        if (obs !== REQ_V) begin
            errors++;
            $display("FAIL reinit_enter got %h exp %h", obs, REQ_V);
        end
        for (int i = 0; i < k; i++) begin
            gnt = 1'b0;
            reinit = 1'($urandom);
            mode_in = 13'($urandom);
            @(posedge HCLK);
            #1;
            checks++;
            if (obs !== REQ_V) begin
                errors++;
                $display("FAIL reinit_wait i=%0d got %h exp %h", i, obs, REQ_V);
            end
        end
        reinit = 1'b0;
        gnt = 1'b1;
        @(posedge HCLK);
        #1;
        checks++;
        if (obs !== REQ_V) begin
            errors++;
            $display("FAIL reinit_gnt got %h exp %h", obs, REQ_V);
        end
        drop = $urandom_range(5, 55);
        for (int c = 0; c <= TRP + N * TRFC + TMRD + 3; c++) begin
            gnt = (c < drop);
            reinit = (c <= TRP + N * TRFC + TMRD) && 1'($urandom);
            mode_in = 13'($urandom);
            @(posedge HCLK);
            #1;
            e = model(c, 0, TRP, TRFC, N, TMRD, m);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reinit_seq c=%0d got %h exp %h", c, obs, e);
            end
        end
        gnt = 1'b0;
        reinit = 1'b0;
    endtask

    task automatic test_ignored_reinit();
        assert_reset();
        checks++;
        if (obs !== RST_V) begin
            errors++;
            $display("FAIL ign_reset got %h exp %h", obs, RST_V);
        end
        release_reset();
        run_powerup(1'b1);
    endtask

    task automatic test_reset_mid();
        int stop;
        logic [22:0] e;
        stop = $urandom_range(TRP + 2 * TRFC + 1, TRP + 3 * TRFC - 1);
        reinit = 1'b1;
        mode_in = 13'h023;
        @(posedge HCLK);
        #1;
        reinit = 1'b0;
        gnt = 1'b1;
        @(posedge HCLK);
        #1;
        for (int c = 0; c <= stop; c++) begin
            @(posedge HCLK);
            #1;
            e = model(c, 0, TRP, TRFC, N, TMRD, 13'h023);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_seq c=%0d got %h exp %h", c, obs, e);
            end
        end
        HRESETn = 1'b0;
        gnt = 1'b0;
        #2;
        checks++;
        if (obs !== RST_V) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", obs, RST_V);
        end
        release_reset();
        run_powerup(1'b0);
    endtask

    task automatic test_edge();
        logic [22:0] e;
        assert_reset();
        checks++;
        if ({obs_e, cs_e} !== {RST_V, 2'b11}) begin
            errors++;
            $display("FAIL edge_reset got %h/%b exp %h/11", obs_e, cs_e, RST_V);
        end
        release_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge HCLK);
            #1;
            e = model(c, 1, 1, 1, 1, 1, 13'h033);
            checks++;
            if (obs_e !== e || cs_e !== {2{e[21]}}) begin
                errors++;
                $display("FAIL edge_seq c=%0d got %h/%b exp %h", c, obs_e, cs_e, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_reinit(5, 13'h023);
        for (int i = 0; i < 3; i++) begin
            test_reinit($urandom_range(0, 6), 13'($urandom));
        end
        test_ignored_reinit();
        test_reset_mid();
        test_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
